// File: rtl/corr_pkg.sv
// ---------------------------------------------------------------------------
// corr_pkg -- definitions shared by the correlator back end (visfinal,
// visaccum and the partial-sum stage).
//   * default datapath sizes
//   * clog2 helper clamped to a minimum of 1 bit
//   * saturation limit helpers for an arbitrary result width
//   * frame-flag encoding {first,last} carried alongside each word
// ---------------------------------------------------------------------------
package corr_pkg;

   localparam int IBITS_DEF = 5;
   localparam int OBITS_DEF = 8;
   localparam int NSUMS_DEF = 4;

   // {first, last} as seen on the stream
   typedef enum logic [1:0] {
      FRAME_MID    = 2'b00,
      FRAME_LAST   = 2'b01,
      FRAME_FIRST  = 2'b10,
      FRAME_SINGLE = 2'b11
   } frame_flag_e;

   // ceil(log2(n)), never less than 1 so a single-channel build still has an index bit
   function automatic int clog2_min1(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) begin
         r = r + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

   // Largest representable value of a w-bit result (w <= 63)
   function automatic logic [63:0] sat_max(input int w, input bit sgn);
      return sgn ? ((64'd1 << (w - 1)) - 64'd1) : ((64'd1 << w) - 64'd1);
   endfunction

   // Smallest representable value, as a 64-bit two's-complement pattern;
   // truncating it to w bits gives the w-bit minimum
   function automatic logic [63:0] sat_min(input int w, input bit sgn);
      return sgn ? ~((64'd1 << (w - 1)) - 64'd1) : 64'd0;
   endfunction

endpackage

// File: rtl/visaccum_add.sv
// ---------------------------------------------------------------------------
// visaccum_add -- combinational extend/add/clamp for one accumulator channel.
//   sum = (first ? 0 : acc) + ext(data)
// ext() sign-extends when SIGNED != 0, zero-extends otherwise.
// Build option VISACCUM_SATURATE_EN: the add is done one bit wider and the
// result is clamped to the OBITS range, with ovf flagging the clamp.
// Without it the add wraps modulo 2^OBITS and ovf is 0.
// Ports:
//   first  in  1      start of frame, discard acc
//   acc    in  OBITS  current channel sum
//   data   in  IBITS  incoming partial visibility
//   sum    out OBITS  new channel sum
//   ovf    out 1      clamp applied to this add
// ---------------------------------------------------------------------------
module visaccum_add
   import corr_pkg::*;
#(
   parameter int IBITS  = IBITS_DEF,
   parameter int OBITS  = OBITS_DEF,
   parameter int SIGNED = 0
) (
   input  logic             first,
   input  logic [OBITS-1:0] acc,
   input  logic [IBITS-1:0] data,
   output logic [OBITS-1:0] sum,
   output logic             ovf
);

`ifdef VISACCUM_SATURATE_EN
   localparam int XW = OBITS + 1;
`else
   localparam int XW = OBITS;
`endif

   logic [XW-1:0] acc_x;
   logic [XW-1:0] data_x;
   logic [XW-1:0] raw;

   always_comb begin
      if (SIGNED != 0) begin
         acc_x  = XW'($signed(acc));
         data_x = XW'($signed(data));
      end else begin
         acc_x  = XW'(acc);
         data_x = XW'(data);
      end
      if (first) begin
         acc_x = '0;
      end
      raw = acc_x + data_x;
      sum = raw[OBITS-1:0];
      ovf = 1'b0;
`ifdef VISACCUM_SATURATE_EN
      // The stored sum is always in range, so the guard bit is enough to
      // detect overflow: sign disagreement (signed) or carry out (unsigned).
      if (SIGNED != 0) begin
         if (raw[XW-1] != raw[XW-2]) begin
            ovf = 1'b1;
            sum = raw[XW-1] ? OBITS'(sat_min(OBITS, 1'b1)) : OBITS'(sat_max(OBITS, 1'b1));
         end
      end else if (raw[XW-1]) begin
         ovf = 1'b1;
         sum = OBITS'(sat_max(OBITS, 1'b0));
      end
`endif
   end

endmodule

// File: rtl/visaccum.sv
// ---------------------------------------------------------------------------
// visaccum -- final-visibility accumulator.
// Takes an interleaved stream of NSUMS partial visibilities per group, sums
// each channel across a frame (first_i .. last_i) and emits the NSUMS totals
// while the frame's last group passes through. Latency valid_i -> valid_o is
// 2 cycles. Build option VISACCUM_SATURATE_EN selects saturating arithmetic
// with a sticky per-channel overflow flag; otherwise sums wrap and
// overflow_o is 0.
// Ports:
//   clock, reset       rising-edge clock, synchronous active-high reset
//   valid_i            data_i carries one channel word
//   first_i / last_i   word belongs to first / last group of a frame
//   data_i   [IBITS]   partial visibility
//   valid_o            data_o carries a finished channel sum
//   first_o / last_o   emitted word is channel 0 / channel NSUMS-1
//   data_o   [OBITS]   finished sum
//   overflow_o         emitted sum was clamped during its frame
// ---------------------------------------------------------------------------
module visaccum
   import corr_pkg::*;
#(
   parameter int IBITS  = IBITS_DEF,
   parameter int OBITS  = OBITS_DEF,
   parameter int NSUMS  = NSUMS_DEF,
   parameter int ABITS  = clog2_min1(NSUMS),
   parameter int SIGNED = 0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             valid_i,
   input  logic             first_i,
   input  logic             last_i,
   input  logic [IBITS-1:0] data_i,
   output logic             valid_o,
   output logic             first_o,
   output logic             last_o,
   output logic [OBITS-1:0] data_o,
   output logic             overflow_o
);

   if (OBITS < IBITS) begin : g_bad_obits
      $error("visaccum: OBITS must be >= IBITS");
   end
   if (NSUMS < 1) begin : g_bad_nsums
      $error("visaccum: NSUMS must be >= 1");
   end

   localparam logic [ABITS-1:0] ADR_LAST = ABITS'(NSUMS - 1);

   logic [ABITS-1:0] adr;

   logic             s1_valid;
   frame_flag_e      s1_flags;
   logic [IBITS-1:0] s1_data;
   logic [ABITS-1:0] s1_adr;
   logic             s1_first;
   logic             s1_last;
   logic             s1_emit;

   logic [OBITS-1:0] acc [NSUMS];
   logic [OBITS-1:0] acc_rd;
   logic [OBITS-1:0] sum;
   logic             add_ovf;
   logic             frame_ovf;

   assign s1_first = (s1_flags == FRAME_FIRST) || (s1_flags == FRAME_SINGLE);
   assign s1_last  = (s1_flags == FRAME_LAST)  || (s1_flags == FRAME_SINGLE);
   assign s1_emit  = s1_valid && s1_last;

   // Combinational read: with NSUMS=1 back-to-back words see the previous
   // write already, so no forwarding path is needed.
   assign acc_rd = acc[s1_adr];

   visaccum_add #(
      .IBITS  (IBITS),
      .OBITS  (OBITS),
      .SIGNED (SIGNED)
   ) u_add (
      .first (s1_first),
      .acc   (acc_rd),
      .data  (s1_data),
      .sum   (sum),
      .ovf   (add_ovf)
   );

   // channel index and stage 1 word register
   always_ff @(posedge clock) begin
      if (reset) begin
         adr      <= '0;
         s1_valid <= 1'b0;
         s1_flags <= FRAME_MID;
         s1_data  <= '0;
         s1_adr   <= '0;
      end else begin
         s1_valid <= valid_i;
         if (valid_i) begin
            s1_data  <= data_i;
            s1_flags <= frame_flag_e'({first_i, last_i});
            s1_adr   <= adr;
            adr      <= (adr == ADR_LAST) ? '0 : adr + 1'b1;
         end
      end
   end

   // Accumulators are deliberately not cleared by reset; first_i reloads them.
   always_ff @(posedge clock) begin
      if (!reset && s1_valid) begin
         acc[s1_adr] <= sum;
      end
   end

`ifdef VISACCUM_SATURATE_EN
   logic ovf_arr [NSUMS];

   assign frame_ovf = add_ovf || (!s1_first && ovf_arr[s1_adr]);

   always_ff @(posedge clock) begin
      if (!reset && s1_valid) begin
         ovf_arr[s1_adr] <= frame_ovf;
      end
   end
`else
   assign frame_ovf = add_ovf;
`endif

   // stage 2 output register
   always_ff @(posedge clock) begin
      if (reset) begin
         valid_o    <= 1'b0;
         first_o    <= 1'b0;
         last_o     <= 1'b0;
         overflow_o <= 1'b0;
         data_o     <= '0;
      end else begin
         valid_o    <= s1_emit;
         first_o    <= s1_emit && (s1_adr == '0);
         last_o     <= s1_emit && (s1_adr == ADR_LAST);
         overflow_o <= s1_emit && frame_ovf;
         if (s1_emit) begin
            data_o <= sum;
         end
      end
   end

endmodule

// File: tb/tb_visaccum.sv
// ---------------------------------------------------------------------------
// tb_visaccum -- self-checking bench for visaccum (IBITS=5, OBITS=8, NSUMS=4).
// Two instances share one stimulus stream: u_dut (SIGNED=0) and u_dut_s
// (SIGNED=1). A frame-level reference model (integer channel sums, clamped
// or wrapped per the arithmetic rule) predicts every emitted word with its
// cycle, channel and overflow flag. Expected results follow the build
// option VISACCUM_SATURATE_EN.
// ---------------------------------------------------------------------------
module tb_visaccum;

   localparam int NS = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       vld = 1'b0;
   logic       fst = 1'b0;
   logic       lst = 1'b0;
   logic [4:0] din = '0;

   logic       u_valid, u_first, u_last, u_ovf;
   logic [7:0] u_data;
   logic       s_valid, s_first, s_last, s_ovf;
   logic [7:0] s_data;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   visaccum #(.IBITS(5), .OBITS(8), .NSUMS(4), .ABITS(2), .SIGNED(0)) u_dut (
      .clock(clk), .reset(rst), .valid_i(vld), .first_i(fst), .last_i(lst), .data_i(din),
      .valid_o(u_valid), .first_o(u_first), .last_o(u_last), .data_o(u_data),
      .overflow_o(u_ovf));

   visaccum #(.IBITS(5), .OBITS(8), .NSUMS(4), .ABITS(2), .SIGNED(1)) u_dut_s (
      .clock(clk), .reset(rst), .valid_i(vld), .first_i(fst), .last_i(lst), .data_i(din),
      .valid_o(s_valid), .first_o(s_first), .last_o(s_last), .data_o(s_data),
      .overflow_o(s_ovf));

   // ---------------- reference model ----------------
   typedef struct {
      int         cyc;
      int         ch;
      logic [7:0] data;
      logic       ovf;
   } exp_t;

   exp_t       eq [2][$];
   int         m_sum [2][NS];
   bit         m_ovf [2][NS];
   int         m_ch = 0;
   logic [7:0] last_d   [2][NS];
   logic       last_ovf [2][NS];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic int madd(input int base, input int dx, input bit sgn, output bit ov);
      int r;
      int hi;
      int lo;
      r  = base + dx;
      hi = sgn ? 127 : 255;
      lo = sgn ? -128 : 0;
      ov = 1'b0;
`ifdef VISACCUM_SATURATE_EN
      if (r > hi) begin
         r  = hi;
         ov = 1'b1;
      end else if (r < lo) begin
         r  = lo;
         ov = 1'b1;
      end
`else
      r = r & 255;
      if (sgn && r > hi) r = r - 256;
      if (r < lo) r = lo;
`endif
      return r;
   endfunction

   task automatic model_word(input logic f, input logic l, input logic [4:0] d);
      for (int k = 0; k < 2; k++) begin
         int   dx;
         int   base;
         bit   ov;
         exp_t e;
         dx   = (k == 1 && d[4]) ? int'(d) - 32 : int'(d);
         base = f ? 0 : m_sum[k][m_ch];
         m_sum[k][m_ch] = madd(base, dx, k == 1, ov);
         m_ovf[k][m_ch] = (f ? 1'b0 : m_ovf[k][m_ch]) | ov;
         if (l) begin
            e.cyc  = cyc + 1;
            e.ch   = m_ch;
            e.data = 8'(m_sum[k][m_ch]);
            e.ovf  = m_ovf[k][m_ch];
            eq[k].push_back(e);
         end
      end
      m_ch = (m_ch + 1) % NS;
   endtask

   // ---------------- output monitor ----------------
   task automatic mon(input int k, input logic v, input logic f, input logic l,
                      input logic [7:0] d, input logic o);
      exp_t  e;
      string p;
      p = (k == 0) ? "u_" : "s_";
      if (v === 1'b1) begin
         if (eq[k].size() == 0) begin
            chk({p, "spurious_valid"}, 32'd1, 32'd0);
         end else begin
            e = eq[k].pop_front();
            chk({p, "latency"}, cyc, e.cyc);
            chk({p, "data"}, 32'(d), 32'(e.data));
            chk({p, "first_o"}, 32'(f), 32'(e.ch == 0));
            chk({p, "last_o"}, 32'(l), 32'(e.ch == NS - 1));
            chk({p, "overflow_o"}, 32'(o), 32'(e.ovf));
            last_d[k][e.ch]   = d;
            last_ovf[k][e.ch] = o;
         end
      end else if (eq[k].size() > 0 && eq[k][0].cyc <= cyc) begin
         e = eq[k].pop_front();
         chk({p, "missing_valid"}, 32'(v), 32'd1);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         mon(0, u_valid, u_first, u_last, u_data, u_ovf);
         mon(1, s_valid, s_first, s_last, s_data, s_ovf);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send(input logic f, input logic l, input logic [4:0] d);
      vld = 1'b1;
      fst = f;
      lst = l;
      din = d;
      @(posedge clk);
      #1;
      model_word(f, l, d);
      vld = 1'b0;
      fst = 1'b0;
      lst = 1'b0;
      din = $urandom_range(0, 31);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((eq[0].size() != 0 || eq[1].size() != 0) && n < 20) begin
         idle(1);
         n++;
      end
      idle(1);
      chk("drain_u", eq[0].size(), 0);
      chk("drain_s", eq[1].size(), 0);
   endtask

   task automatic frame(input int ngroups, input logic [4:0] d);
      for (int g = 0; g < ngroups; g++) begin
         for (int c = 0; c < NS; c++) begin
            send(g == 0, g == ngroups - 1, d);
         end
      end
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      vld = 1'b0;
      fst = 1'b0;
      lst = 1'b0;
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
         chk("rst_u_valid", 32'(u_valid), 32'd0);
         chk("rst_s_valid", 32'(s_valid), 32'd0);
      end
      chk("rst_u_data", 32'(u_data), 32'd0);
      chk("rst_u_flags", {29'd0, u_first, u_last, u_ovf}, 32'd0);
      chk("rst_s_flags", {29'd0, s_first, s_last, s_ovf}, 32'd0);
      @(posedge clk);
      #1;
      rst  = 1'b0;
      m_ch = 0;
      eq[0].delete();
      eq[1].delete();
   endtask

   task automatic chk_frame(input string nm, input logic [7:0] eu, input logic ou,
                            input logic [7:0] es, input logic os);
      for (int c = 0; c < NS; c++) begin
         chk({nm, "_u"}, 32'(last_d[0][c]), 32'(eu));
         chk({nm, "_u_ovf"}, 32'(last_ovf[0][c]), 32'(ou));
         chk({nm, "_s"}, 32'(last_d[1][c]), 32'(es));
         chk({nm, "_s_ovf"}, 32'(last_ovf[1][c]), 32'(os));
      end
   endtask

   task automatic clear_last();
      for (int k = 0; k < 2; k++) begin
         for (int c = 0; c < NS; c++) begin
            last_d[k][c]   = 8'hXX;
            last_ovf[k][c] = 1'bX;
         end
      end
   endtask

   // ---------------- vector table: single-group frames ----------------
   typedef struct {
      logic [4:0] data;
      logic [7:0] exp_u;
      logic [7:0] exp_s;
   } vec_t;

   vec_t tbl [8];

   initial begin
      tbl[0] = '{5'd1,  8'h01, 8'h01};
      tbl[1] = '{5'd2,  8'h02, 8'h02};
      tbl[2] = '{5'd3,  8'h03, 8'h03};
      tbl[3] = '{5'd4,  8'h04, 8'h04};
      tbl[4] = '{5'h1F, 8'h1F, 8'hFF};
      tbl[5] = '{5'h10, 8'h10, 8'hF0};
      tbl[6] = '{5'h0F, 8'h0F, 8'h0F};
      tbl[7] = '{5'h11, 8'h11, 8'hF1};

      do_reset(3);

      // 8 groups of 31
      clear_last();
      frame(8, 5'd31);
      drain();
      chk_frame("sum31x8", 8'd248, 1'b0, 8'hF8, 1'b0);

      // 8 groups of 5'h10: unsigned 128, signed -128 (exactly the minimum)
      clear_last();
      frame(8, 5'h10);
      drain();
      chk_frame("sum10x8", 8'h80, 1'b0, 8'h80, 1'b0);

      // 9 groups of 31: unsigned overflows 8 bits
      clear_last();
      frame(9, 5'd31);
      drain();
`ifdef VISACCUM_SATURATE_EN
      chk_frame("sum31x9", 8'd255, 1'b1, 8'hF7, 1'b0);
`else
      chk_frame("sum31x9", 8'd23, 1'b0, 8'hF7, 1'b0);
`endif

      // following frame of 1s must not inherit the sticky overflow
      clear_last();
      frame(2, 5'd1);
      drain();
      chk_frame("sum1x2", 8'd2, 1'b0, 8'd2, 1'b0);

      // single-group frames from the table, gaps between words
      for (int i = 0; i < 8; i++) begin
         send(1'b1, 1'b1, tbl[i].data);
         idle(1);
         @(negedge clk);
         chk("tbl_u_valid", 32'(u_valid), 32'd1);
         chk("tbl_u_data", 32'(u_data), 32'(tbl[i].exp_u));
         chk("tbl_s_data", 32'(s_data), 32'(tbl[i].exp_s));
         chk("tbl_u_first", 32'(u_first), 32'(i % NS == 0));
      end
      drain();

      // random frames with random valid gaps
      for (int fr = 0; fr < 25; fr++) begin
         int ng;
         ng = $urandom_range(1, 4);
         for (int g = 0; g < ng; g++) begin
            for (int c = 0; c < NS; c++) begin
               send(g == 0, g == ng - 1, 5'($urandom_range(0, 31)));
               idle($urandom_range(0, 2));
            end
         end
      end
      drain();

      // reset in the middle of a frame, then a fresh frame
      frame(1, 5'd7);
      send(1'b0, 1'b0, 5'd9);
      send(1'b0, 1'b0, 5'd9);
      do_reset(2);
      clear_last();
      frame(2, 5'd3);
      drain();
      chk_frame("post_reset", 8'd6, 1'b0, 8'd6, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // hard time limit so the run always ends
   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
